// File: rtl/carry_chain_seq.sv
// Wide add/subtract built by time-multiplexing one 8-bit ripple-carry slice.
// One byte is processed per cycle, least significant byte first, with the carry registered between bytes.
module carry_chain_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   in_a,
  input  logic [8*WORDS-1:0]   in_b,
  input  logic                 in_sub,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_ovf
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [7:0]       r_sumChunks [WORDS];
  logic             r_cout;
  logic             r_ovf;

  logic [7:0]       w_aChunks [WORDS];
  logic [7:0]       w_bChunks [WORDS];
  logic [7:0]       w_aChunk;
  logic [7:0]       w_bChunk;
  logic [7:0]       w_p;
  logic [7:0]       w_s;
  logic             w_cout;
  logic             w_ovf;

  // Model of the fabric slice: each stage propagates CIN when P is set, otherwise passes DI (G).
  function automatic logic [8:0] carry8(input logic [7:0] p, input logic [7:0] g, input logic cin);
    logic [8:0] c;
    logic [7:0] s;
    c[0] = cin;
    s    = '0;
    for (int i = 0; i < 8; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = p[i] ? c[i] : g[i];
    end
    return {c[8], s};
  endfunction

  for (genvar k = 0; k < WORDS; k++) begin : g_chunks
    assign w_aChunks[k]        = r_a[8*k +: 8];
    assign w_bChunks[k]        = r_b[8*k +: 8];
    assign out_sum[8*k +: 8]   = r_sumChunks[k];
  end

  assign w_aChunk        = w_aChunks[r_idx];
  assign w_bChunk        = w_bChunks[r_idx];
  assign w_p             = w_aChunk ^ w_bChunk;
  assign {w_cout, w_s}   = carry8(w_p, w_aChunk, r_carry);
  assign w_ovf           = (w_aChunk[7] == w_bChunk[7]) && (w_s[7] != w_aChunk[7]);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < WORDS; k++) r_sumChunks[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, with the borrow-in folded into the initial carry.
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_cin ^ in_sub;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sumChunks[r_idx] <= w_s;
          r_carry            <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_chain_seq.sv
// Directed self-checking bench for carry_chain_seq with WORDS=4 (32-bit operands).
// Expected results are hand-computed constants.
module tb_carry_chain_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int errorCount;
  int checkCount;

  carry_chain_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request; the edge at which it is taken is the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
    int waitCycles;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      stepCycle();
      waitCycles++;
    end
    checkOutput("in_ready before request", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
    in_valid = 1'b1;
    stepCycle();
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1234_5678;
    in_sub   = ~sub;
    in_cin   = ~cin;
  endtask

  task automatic waitResult(input string tag);
    int edges;
    edges = 0;
    while (!out_valid && edges < 20) begin
      stepCycle();
      edges++;
    end
    checkOutput({tag, " latency"}, 32'(edges), 32'd4);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin,
                       input logic [31:0] expSum, input logic expCout, input logic expOvf);
    applyStimulus(a, b, sub, cin);
    waitResult(tag);
    checkOutput({tag, " sum"},  out_sum, expSum);
    checkOutput({tag, " cout"}, 32'(out_cout), 32'(expCout));
    checkOutput({tag, " ovf"},  32'(out_ovf), 32'(expOvf));
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready back"},  32'(in_ready), 32'd1);
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_sub     = 1'b0;
    in_cin     = 1'b0;
    out_ready  = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;

    checkOutput("reset in_ready",  32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset sum",       out_sum, 32'd0);
    checkOutput("reset cout",      32'(out_cout), 32'd0);
    checkOutput("reset ovf",       32'(out_ovf), 32'd0);

    runOp("add ff+1",        32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    runOp("add ripple",      32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    runOp("add ovf",         32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    runOp("sub 5-7",         32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runOp("sub min-1",       32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    runOp("sub borrow-in",   32'h0000_1000, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0FFE, 1'b1, 1'b0);

    // Backpressure: result must hold while extra requests are refused.
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    waitResult("bp");
    for (int i = 0; i < 3; i++) begin
      in_a     = 32'h0000_0001;
      in_b     = 32'h0000_0001;
      in_sub   = 1'b0;
      in_cin   = 1'b0;
      in_valid = (i != 1);
      stepCycle();
      checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
      checkOutput("bp in_ready low",   32'(in_ready), 32'd0);
      checkOutput("bp sum stable",     out_sum, 32'h2345_6789);
      checkOutput("bp cout stable",    32'(out_cout), 32'd0);
      checkOutput("bp ovf stable",     32'(out_ovf), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp release in_ready",  32'(in_ready), 32'd1);
    checkOutput("bp sum kept",          out_sum, 32'h2345_6789);
    stepCycle();
    checkOutput("bp no queued request", 32'(in_ready), 32'd1);

    // Reset while the third chunk is being processed discards the operation.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    checkOutput("mid-run reset in_ready",  32'(in_ready), 32'd1);
    checkOutput("mid-run reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-run reset sum",       out_sum, 32'd0);
    runOp("post-reset 1+1", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
